// File: rtl/ray_column_pkg.sv
// Shared field widths, beat layout and types for the ray column buffer.
// The statistics counters are enabled by defining RAY_COLUMN_BUF_STATS_EN.
package ray_column_pkg;

  localparam int SCREEN_WIDTH_DEF = 320;
  localparam int SCREEN_HEIGHT    = 180;

  localparam int HCOUNT_W  = 9;
  localparam int LINEH_W   = 8;
  localparam int MAPDATA_W = 5;
  localparam int WALLX_W   = 16;
  localparam int BEAT_W    = 39;

  localparam int HCOUNT_LSB   = 30;
  localparam int LINEH_LSB    = 22;
  localparam int WALLTYPE_BIT = 21;
  localparam int MAPDATA_LSB  = 16;
  localparam int WALLX_LSB    = 0;

  typedef struct packed {
    logic [LINEH_W-1:0]   lineHeight;
    logic                 wallType;
    logic [MAPDATA_W-1:0] mapData;
    logic [WALLX_W-1:0]   wallX;
  } ray_column_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } colbuf_state_t;

  function automatic ray_column_t unpack_beat(input logic [BEAT_W-1:0] beat);
    ray_column_t col;
    col.lineHeight = beat[LINEH_LSB +: LINEH_W];
    col.wallType   = beat[WALLTYPE_BIT];
    col.mapData    = beat[MAPDATA_LSB +: MAPDATA_W];
    col.wallX      = beat[WALLX_LSB +: WALLX_W];
    return col;
  endfunction

endpackage

// File: rtl/column_bank.sv
// One column bank: simple dual-port RAM with a single write port and a
// registered read port, one ray_column_t entry per screen column.
module column_bank
  import ray_column_pkg::*;
#(
  parameter int DEPTH = SCREEN_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [HCOUNT_W-1:0] i_waddr,
  input  ray_column_t         i_wdata,
  input  logic [HCOUNT_W-1:0] i_raddr,
  output ray_column_t         o_rdata
);

  ray_column_t r_mem [DEPTH];

  // NOTE: the array has no reset; per-bank valid bitmaps outside gate stale contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ray_column_buffer.sv
// Ping-pong column buffer between the DDA result stream and the column renderer.
// Defining RAY_COLUMN_BUF_STATS_EN adds frame, dropped-beat and stall counters.
module ray_column_buffer
  import ray_column_pkg::*;
#(
  parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF
) (
  input  logic                 pixel_clk_in,
  input  logic                 rst_n_in,
  input  logic                 ray_in_tvalid,
  input  logic [BEAT_W-1:0]    ray_in_tdata,
  input  logic                 ray_in_tlast,
  output logic                 ray_in_tready,
  input  logic                 frame_swap_in,
  input  logic [HCOUNT_W-1:0]  rd_hcount_in,
  output logic                 col_valid_out,
  output logic [LINEH_W-1:0]   col_lineHeight_out,
  output logic                 col_wallType_out,
  output logic [MAPDATA_W-1:0] col_mapData_out,
  output logic [WALLX_W-1:0]   col_wallX_out,
  output logic                 frame_ready_out
`ifdef RAY_COLUMN_BUF_STATS_EN
  ,
  output logic [15:0]          frames_out,
  output logic [15:0]          dropped_out,
  output logic [15:0]          stall_out
`endif
);

  localparam logic [HCOUNT_W-1:0] LAST_COL = HCOUNT_W'(SCREEN_WIDTH - 1);

  colbuf_state_t           r_state;
  logic                    r_tready;
  logic                    r_frame_ready;
  logic                    r_rd_bank;
  logic [SCREEN_WIDTH-1:0] r_valid [2];
  logic                    r_rd_valid;
  logic                    r_rd_sel;

  logic [HCOUNT_W-1:0] w_hcount;
  logic                w_xfer;
  logic                w_in_range;
  logic                w_wr_en;
  logic                w_swap;
  logic                w_rd_in_range;
  logic [HCOUNT_W-1:0] w_rd_addr;
  ray_column_t         w_wdata;
  ray_column_t         w_rdata0;
  ray_column_t         w_rdata1;
  ray_column_t         w_rd_col;
  ray_column_t         w_col;

  assign ray_in_tready   = r_tready;
  assign frame_ready_out = r_frame_ready;

  assign w_hcount   = ray_in_tdata[HCOUNT_LSB +: HCOUNT_W];
  assign w_wdata    = unpack_beat(ray_in_tdata);
  assign w_xfer     = ray_in_tvalid && r_tready;
  assign w_in_range = (w_hcount <= LAST_COL);
  assign w_wr_en    = w_xfer && w_in_range;
  assign w_swap     = (r_state == FULL) && frame_swap_in;

  // Out-of-range read requests are steered to a legal address and masked invalid.
  assign w_rd_in_range = (rd_hcount_in <= LAST_COL);
  assign w_rd_addr     = w_rd_in_range ? rd_hcount_in : '0;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= FILL;
      r_tready      <= 1'b1;
      r_frame_ready <= 1'b0;
      r_rd_bank     <= 1'b0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_xfer && ray_in_tlast) begin
            r_state       <= FULL;
            r_tready      <= 1'b0;
            r_frame_ready <= 1'b1;
          end
        end
        FULL: begin
          if (frame_swap_in) begin
            r_state       <= FILL;
            r_tready      <= 1'b1;
            r_frame_ready <= 1'b0;
            r_rd_bank     <= ~r_rd_bank;
          end
        end
      endcase
    end
  end

  // On a swap the bank just retired from display becomes the write bank.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
    end else if (w_swap) begin
      r_valid[r_rd_bank] <= '0;
    end else if (w_wr_en) begin
      r_valid[~r_rd_bank][w_hcount] <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rd_valid <= 1'b0;
      r_rd_sel   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_in_range && r_valid[r_rd_bank][w_rd_addr];
      r_rd_sel   <= r_rd_bank;
    end
  end

  column_bank #(.DEPTH(SCREEN_WIDTH)) u_bank0 (
    .clk     (pixel_clk_in),
    .i_we    (w_wr_en && r_rd_bank),
    .i_waddr (w_hcount),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata0)
  );

  column_bank #(.DEPTH(SCREEN_WIDTH)) u_bank1 (
    .clk     (pixel_clk_in),
    .i_we    (w_wr_en && !r_rd_bank),
    .i_waddr (w_hcount),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata1)
  );

  assign w_rd_col = r_rd_sel ? w_rdata1 : w_rdata0;
  assign w_col    = r_rd_valid ? w_rd_col : '0;

  assign col_valid_out      = r_rd_valid;
  assign col_lineHeight_out = w_col.lineHeight;
  assign col_wallType_out   = w_col.wallType;
  assign col_mapData_out    = w_col.mapData;
  assign col_wallX_out      = w_col.wallX;

`ifdef RAY_COLUMN_BUF_STATS_EN
  logic [15:0] r_frames;
  logic [15:0] r_dropped;
  logic [15:0] r_stall;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frames  <= '0;
      r_dropped <= '0;
      r_stall   <= '0;
    end else begin
      if (w_swap)                   r_frames  <= r_frames + 16'd1;
      if (w_xfer && !w_in_range)    r_dropped <= r_dropped + 16'd1;
      if (ray_in_tvalid && !r_tready) r_stall <= r_stall + 16'd1;
    end
  end

  assign frames_out  = r_frames;
  assign dropped_out = r_dropped;
  assign stall_out   = r_stall;
`endif

endmodule

// File: tb/tb_ray_column_buffer.sv
// Self-checking bench for ray_column_buffer: a frame-level model (filling frame
// and displayed frame as plain arrays) checked every cycle, plus literal checks.
module tb_ray_column_buffer;

  localparam int W = 320;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tvalid = 1'b0;
  logic [38:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        tready;
  logic        swap = 1'b0;
  logic [8:0]  rd_hcount = '0;
  logic        col_valid;
  logic [7:0]  col_lh;
  logic        col_wt;
  logic [4:0]  col_md;
  logic [15:0] col_wx;
  logic        frame_ready;
`ifdef RAY_COLUMN_BUF_STATS_EN
  logic [15:0] frames_out, dropped_out, stall_out;
`endif

  always #5 clk = ~clk;

  ray_column_buffer #(.SCREEN_WIDTH(W)) dut (
    .pixel_clk_in       (clk),
    .rst_n_in           (rst_n),
    .ray_in_tvalid      (tvalid),
    .ray_in_tdata       (tdata),
    .ray_in_tlast       (tlast),
    .ray_in_tready      (tready),
    .frame_swap_in      (swap),
    .rd_hcount_in       (rd_hcount),
    .col_valid_out      (col_valid),
    .col_lineHeight_out (col_lh),
    .col_wallType_out   (col_wt),
    .col_mapData_out    (col_md),
    .col_wallX_out      (col_wx),
    .frame_ready_out    (frame_ready)
`ifdef RAY_COLUMN_BUF_STATS_EN
    ,
    .frames_out         (frames_out),
    .dropped_out        (dropped_out),
    .stall_out          (stall_out)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a filling frame, a displayed frame, and a "frame complete" flag.
  logic [29:0] m_fill_d [W];
  bit          m_fill_v [W];
  logic [29:0] m_disp_d [W];
  bit          m_disp_v [W];
  bit          m_full;
  logic [30:0] m_exp;
  logic [15:0] m_frames, m_dropped, m_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 1'b0;
      m_exp  = '0;
      m_frames = '0; m_dropped = '0; m_stall = '0;
      for (int i = 0; i < W; i++) begin
        m_fill_v[i] = 1'b0;
        m_disp_v[i] = 1'b0;
      end
    end else begin
      if (rd_hcount < W && m_disp_v[rd_hcount]) m_exp = {1'b1, m_disp_d[rd_hcount]};
      else                                      m_exp = '0;
      if (tvalid && m_full) m_stall = m_stall + 16'd1;
      if (m_full) begin
        if (swap) begin
          for (int i = 0; i < W; i++) begin
            m_disp_d[i] = m_fill_d[i];
            m_disp_v[i] = m_fill_v[i];
            m_fill_v[i] = 1'b0;
          end
          m_full   = 1'b0;
          m_frames = m_frames + 16'd1;
        end
      end else if (tvalid) begin
        int h;
        h = int'(tdata[38:30]);
        if (h < W) begin
          m_fill_d[h] = tdata[29:0];
          m_fill_v[h] = 1'b1;
        end else begin
          m_dropped = m_dropped + 16'd1;
        end
        if (tlast) m_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cycle", {31'd0, tready, frame_ready, col_valid, col_lh, col_wt, col_md, col_wx},
            {31'd0, !m_full, m_full, m_exp});
`ifdef RAY_COLUMN_BUF_STATS_EN
      check("frames",  frames_out,  m_frames);
      check("dropped", dropped_out, m_dropped);
      check("stall",   stall_out,   m_stall);
`endif
    end
  end

  function automatic logic [29:0] col_data(input int i);
    logic [15:0] wx;
    logic [8:0]  iv;
    iv = 9'(i);
    wx = 16'h1000 + 16'(i);
    return {iv[7:0], iv[0], iv[4:0], wx};
  endfunction

  // All tasks start and end at posedge+1.
  task automatic send(input logic [8:0] h, input logic [29:0] d, input bit last);
    int budget;
    tvalid = 1'b1;
    tdata  = {h, d};
    tlast  = last;
    budget = 0;
    @(negedge clk);
    while (!tready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!tready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    @(posedge clk); #1;
    swap = 1'b0;
  endtask

  task automatic rd(input string name, input logic [8:0] h, input logic v,
                    input logic [7:0] lh, input logic [15:0] wx);
    rd_hcount = h;
    @(posedge clk);
    @(negedge clk);
    check(name, {39'd0, col_valid, col_lh, col_wx}, {39'd0, v, lh, wx});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Reset state
    @(negedge clk);
    check("rst_ready", {62'd0, tready, frame_ready}, {62'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    rd("rst_col0",   9'd0,   1'b0, 8'd0, 16'd0);
    rd("rst_col5",   9'd5,   1'b0, 8'd0, 16'd0);
    rd("rst_col319", 9'd319, 1'b0, 8'd0, 16'd0);

    // Full frame, tlast on the last column
    for (int i = 0; i < W; i++) send(9'(i), col_data(i), i == W - 1);

    // Hold a beat while the frame waits for the display boundary
    tvalid = 1'b1;
    tdata  = {9'd300, 8'd30, 1'b1, 5'd3, 16'hBEEF};
    tlast  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("held_stall", {62'd0, tready, frame_ready}, {62'd0, 1'b0, 1'b1});
      @(posedge clk); #1;
    end
    pulse_swap();
    @(negedge clk);
    check("held_release", {62'd0, tready, frame_ready}, {62'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    tvalid = 1'b0;

    rd("f1_col5",   9'd5,   1'b1, 8'd5,    16'h1005);
    rd("f1_col319", 9'd319, 1'b1, 8'h3F,   16'h113F);
    rd("f1_col11",  9'd11,  1'b1, 8'd11,   16'h100B);

    // Swap while filling is ignored
    pulse_swap();
    rd("fill_swap_col11", 9'd11, 1'b1, 8'd11, 16'h100B);

    // Sparse frame: 300 (held beat) then 10 with tlast
    send(9'd10, {8'd77, 1'b0, 5'd9, 16'hCAFE}, 1'b1);
    pulse_swap();
    rd("f2_col10",  9'd10,  1'b1, 8'd77, 16'hCAFE);
    rd("f2_col300", 9'd300, 1'b1, 8'd30, 16'hBEEF);
    rd("f2_col11",  9'd11,  1'b0, 8'd0,  16'd0);

    // Out-of-range beat dropped; tlast beat coincides with a swap pulse
    send(9'd400, {8'd99, 1'b1, 5'd31, 16'hDEAD}, 1'b0);
    tvalid = 1'b1;
    tdata  = {9'd0, 8'd42, 1'b1, 5'd7, 16'h4242};
    tlast  = 1'b1;
    swap   = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    swap   = 1'b0;
    @(negedge clk);
    check("same_cycle_swap", {62'd0, tready, frame_ready}, {62'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    pulse_swap();
    rd("f3_col0",   9'd0,   1'b1, 8'd42, 16'h4242);
    rd("f3_col10",  9'd10,  1'b0, 8'd0,  16'd0);
    rd("f3_col300", 9'd300, 1'b0, 8'd0,  16'd0);
`ifdef RAY_COLUMN_BUF_STATS_EN
    @(negedge clk);
    check("lit_dropped", {48'd0, dropped_out}, 64'd1);
    check("lit_frames",  {48'd0, frames_out},  64'd3);
    @(posedge clk); #1;
`endif

    // Out-of-range read requests
    rd("rd_oor_400", 9'd400, 1'b0, 8'd0, 16'd0);
    rd("rd_oor_511", 9'd511, 1'b0, 8'd0, 16'd0);

    // Reset in the middle of a frame
    for (int i = 0; i < 100; i++) send(9'(i), col_data(i + 5), 1'b0);
    tvalid = 1'b1;
    tdata  = {9'd100, col_data(100)};
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    tvalid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_ready", {62'd0, tready, frame_ready}, {62'd0, 1'b1, 1'b0});
`ifdef RAY_COLUMN_BUF_STATS_EN
    check("post_rst_stats", {16'd0, frames_out, dropped_out, stall_out}, 64'd0);
`endif
    @(posedge clk); #1;
    rd("post_rst_col5", 9'd5, 1'b0, 8'd0, 16'd0);
    pulse_swap();
    rd("post_rst_swap_col5", 9'd5, 1'b0, 8'd0, 16'd0);
    rd("post_rst_swap_col0", 9'd0, 1'b0, 8'd0, 16'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
